// File: rtl/axi_reg_pkg.sv
// Shared types, encodings and beat-legality decode for the AXI4
// register responder.
package axi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WDATA,
    WRESP,
    RDATA
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam int IDX_W = 10;

  function automatic logic idx_legal(
    input logic [IDX_W-1:0] idx,
    input int               num_regs
  );
    return int'({{(32-IDX_W){1'b0}}, idx}) < num_regs;
  endfunction

  function automatic logic beat_ok(
    input logic [2:0]       size,
    input logic [1:0]       burst,
    input logic [IDX_W-1:0] idx,
    input int               num_regs
  );
    return size == 3'd2 && burst != BURST_WRAP &&
           idx_legal(idx, num_regs);
  endfunction

endpackage

// File: rtl/axi_reg_slave_if.sv
// AXI4 bus bundle between an interconnect master port and a
// responder.
interface axi_bus #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 3,
  parameter int AXI_USER_WIDTH = 1
);
  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic                        aw_valid;
  logic                        aw_ready;

  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;
  logic                        w_valid;
  logic                        w_ready;

  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [1:0]                  b_resp;
  logic [AXI_USER_WIDTH-1:0]   b_user;
  logic                        b_valid;
  logic                        b_ready;

  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic                        ar_valid;
  logic                        ar_ready;

  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [AXI_USER_WIDTH-1:0]   r_user;
  logic                        r_valid;
  logic                        r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/axi_reg_bank.sv
// Register storage with byte-strobe merge, read mux and the flat
// export of all register contents.
module axi_reg_bank
  import axi_reg_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [IDX_W-1:0]       widx,
  input  logic [31:0]            wdata,
  input  logic [3:0]             wstrb,
  input  logic [IDX_W-1:0]       ridx,
  output logic [31:0]            rdata,
  output logic [32*NUM_REGS-1:0] regs_o
);

  logic [NUM_REGS-1:0][31:0] regs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else if (we) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (widx == IDX_W'(i)) begin
          for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) regs[i][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ridx == IDX_W'(i)) rdata = regs[i];
    end
  end

  assign regs_o = regs;

endmodule

// File: rtl/axi_reg_slave.sv
// AXI4 responder backed by a bank of 32-bit registers; one
// outstanding burst at a time, FIXED/INCR, strobes and ID echo.
module axi_reg_slave
  import axi_reg_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH     = 32,
  parameter int AXI_DATA_WIDTH     = 32,
  parameter int AXI_ID_SLAVE_WIDTH = 3,
  parameter int AXI_USER_WIDTH     = 1,
  parameter int NUM_REGS           = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_bus.slave                  slave,
  output logic [32*NUM_REGS-1:0] regs_o
);

  state_t state, state_n;

  logic [AXI_ID_SLAVE_WIDTH-1:0] id_q;
  logic [IDX_W-1:0]              idx_q, idx_nxt, ridx;
  logic [7:0]                    len_q, cnt_q;
  logic [2:0]                    size_q;
  logic [1:0]                    burst_q, rresp_q;
  logic                          err_q;
  logic [AXI_DATA_WIDTH-1:0]     rdata_q;
  logic [31:0]                   bank_rdata;
  logic [AXI_ADDR_WIDTH-1:0]     aw_addr, ar_addr;
  logic                          wbeat_ok, rbeat_ok, last_beat;
  logic                          aw_hs, w_hs, ar_hs, r_hs;
  logic                          unused_ok;

  assign aw_addr   = slave.aw_addr;
  assign ar_addr   = slave.ar_addr;
  assign unused_ok = ^{slave.w_last, aw_addr, ar_addr};

  assign idx_nxt   = (burst_q == BURST_FIXED) ? idx_q
                                              : idx_q + 1'b1;
  assign last_beat = cnt_q == len_q;
  assign wbeat_ok  = beat_ok(size_q, burst_q, idx_q, NUM_REGS);

  assign aw_hs = slave.aw_valid && slave.aw_ready;
  assign w_hs  = slave.w_valid && slave.w_ready;
  assign ar_hs = slave.ar_valid && slave.ar_ready;
  assign r_hs  = slave.r_valid && slave.r_ready;

  // In IDLE the read port looks at the incoming AR so the first
  // beat is already registered when RVALID rises.
  always_comb begin
    if (state == IDLE) begin
      ridx     = ar_addr[11:2];
      rbeat_ok = beat_ok(slave.ar_size, slave.ar_burst,
                         ar_addr[11:2], NUM_REGS);
    end else begin
      ridx     = idx_nxt;
      rbeat_ok = beat_ok(size_q, burst_q, idx_nxt, NUM_REGS);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n        = state;
    slave.aw_ready = 1'b0;
    slave.ar_ready = 1'b0;
    slave.w_ready  = 1'b0;
    slave.b_valid  = 1'b0;
    slave.r_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        slave.aw_ready = !rst;
        slave.ar_ready = !rst && !slave.aw_valid;
        if (slave.aw_valid)      state_n = WDATA;
        else if (slave.ar_valid) state_n = RDATA;
      end
      WDATA: begin
        slave.w_ready = 1'b1;
        if (slave.w_valid && last_beat) state_n = WRESP;
      end
      WRESP: begin
        slave.b_valid = 1'b1;
        if (slave.b_ready) state_n = IDLE;
      end
      RDATA: begin
        slave.r_valid = 1'b1;
        if (slave.r_ready && last_beat) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q    <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        id_q    <= slave.aw_id;
        idx_q   <= aw_addr[11:2];
        len_q   <= slave.aw_len;
        size_q  <= slave.aw_size;
        burst_q <= slave.aw_burst;
        cnt_q   <= '0;
        err_q   <= 1'b0;
      end
      if (w_hs) begin
        err_q <= err_q | !wbeat_ok;
        idx_q <= idx_nxt;
        cnt_q <= cnt_q + 1'b1;
      end
      if (ar_hs) begin
        id_q    <= slave.ar_id;
        idx_q   <= ar_addr[11:2];
        len_q   <= slave.ar_len;
        size_q  <= slave.ar_size;
        burst_q <= slave.ar_burst;
        cnt_q   <= '0;
      end
      if (ar_hs || (r_hs && !last_beat)) begin
        rdata_q <= rbeat_ok ? bank_rdata : '0;
        rresp_q <= rbeat_ok ? RESP_OKAY : RESP_SLVERR;
      end
      if (r_hs && !last_beat) begin
        idx_q <= idx_nxt;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign slave.b_id   = id_q;
  assign slave.b_resp = err_q ? RESP_SLVERR : RESP_OKAY;
  assign slave.b_user = '0;
  assign slave.r_id   = id_q;
  assign slave.r_data = rdata_q;
  assign slave.r_resp = rresp_q;
  assign slave.r_last = last_beat;
  assign slave.r_user = '0;

  axi_reg_bank #(
    .NUM_REGS(NUM_REGS)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (w_hs && wbeat_ok),
    .widx  (idx_q),
    .wdata (slave.w_data),
    .wstrb (slave.w_strb),
    .ridx  (ridx),
    .rdata (bank_rdata),
    .regs_o(regs_o)
  );

endmodule

// File: tb/tb_axi_reg_slave.sv
// Self-checking bench for axi_reg_slave: directed scenarios plus
// random bursts checked against an array-based register model.
module tb_axi_reg_slave;
  import axi_reg_pkg::*;

  localparam int NR  = 8;
  localparam int TMO = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [32*NR-1:0] regs_o;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi_bus #(
    .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(32),
    .AXI_ID_WIDTH  (3),
    .AXI_USER_WIDTH(1)
  ) bus ();

  axi_reg_slave #(
    .AXI_ADDR_WIDTH    (32),
    .AXI_DATA_WIDTH    (32),
    .AXI_ID_SLAVE_WIDTH(3),
    .AXI_USER_WIDTH    (1),
    .NUM_REGS          (NR)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .slave (bus),
    .regs_o(regs_o)
  );

  logic [31:0] model [NR];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rd [16];
  logic [1:0]  rr [16];
  logic        rl [16];
  logic [1:0]  b_resp_got;
  logic [2:0]  b_id_got, r_id_got;
  int          r_beats, w_lat, b_lat, r_lat;

  // ---------------- reference model ----------------
  function automatic int m_idx(logic [31:0] addr,
                               logic [1:0] burst, int k);
    int base;
    base = int'(addr[11:2]);
    if (burst == BURST_FIXED) return base;
    return (base + k) % 1024;
  endfunction

  function automatic bit m_ok(logic [2:0] size,
                              logic [1:0] burst, int idx);
    return size == 3'd2 && burst != BURST_WRAP && idx < NR;
  endfunction

  task automatic model_write(input logic [31:0] addr,
                             input int len,
                             input logic [2:0] size,
                             input logic [1:0] burst,
                             output logic [1:0] resp);
    int idx;
    resp = RESP_OKAY;
    for (int k = 0; k <= len; k++) begin
      idx = m_idx(addr, burst, k);
      if (m_ok(size, burst, idx)) begin
        for (int b = 0; b < 4; b++)
          if (ws[k][b]) model[idx][8*b +: 8] = wd[k][8*b +: 8];
      end else begin
        resp = RESP_SLVERR;
      end
    end
  endtask

  function automatic logic [32*NR-1:0] model_flat();
    logic [32*NR-1:0] f;
    for (int i = 0; i < NR; i++) f[32*i +: 32] = model[i];
    return f;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) model[i] = '0;
  endtask

  // ---------------- bus driver ----------------
  task automatic bus_idle();
    bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0;
    bus.aw_size = '0; bus.aw_burst = '0; bus.aw_valid = 1'b0;
    bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0;
    bus.w_valid = 1'b0; bus.b_ready = 1'b0;
    bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0;
    bus.ar_size = '0; bus.ar_burst = '0; bus.ar_valid = 1'b0;
    bus.r_ready = 1'b0;
  endtask

  task automatic timeout(input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL timeout_%s waited %0d cycles", what, TMO);
  endtask

  task automatic do_write(input logic [2:0] id,
                          input logic [31:0] addr,
                          input logic [7:0] len,
                          input logic [2:0] size,
                          input logic [1:0] burst);
    int t;
    bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len;
    bus.aw_size = size; bus.aw_burst = burst;
    bus.aw_valid = 1'b1;
    #1; t = 0;
    while (!bus.aw_ready && t < TMO) begin
      @(negedge clk); #1; t++;
    end
    if (t >= TMO) timeout("aw");
    @(negedge clk);
    bus.aw_valid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      bus.w_data = wd[k]; bus.w_strb = ws[k];
      bus.w_last = (k == int'(len)); bus.w_valid = 1'b1;
      #1; t = 0;
      while (!bus.w_ready && t < TMO) begin
        @(negedge clk); #1; t++;
      end
      if (t >= TMO) timeout("w");
      if (k == 0) w_lat = t;
      @(negedge clk);
    end
    bus.w_valid = 1'b0; bus.w_last = 1'b0;
    bus.b_ready = 1'b1;
    #1; t = 0;
    while (!bus.b_valid && t < TMO) begin
      @(negedge clk); #1; t++;
    end
    if (t >= TMO) timeout("b");
    b_lat = t;
    b_id_got = bus.b_id;
    b_resp_got = bus.b_resp;
    @(negedge clk);
    bus.b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] id,
                         input logic [31:0] addr,
                         input logic [7:0] len,
                         input logic [2:0] size,
                         input logic [1:0] burst,
                         input bit toggle);
    int t, cyc;
    bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len;
    bus.ar_size = size; bus.ar_burst = burst;
    bus.ar_valid = 1'b1;
    #1; t = 0;
    while (!bus.ar_ready && t < TMO) begin
      @(negedge clk); #1; t++;
    end
    if (t >= TMO) timeout("ar");
    @(negedge clk);
    bus.ar_valid = 1'b0;
    r_beats = 0; r_lat = -1; cyc = 0;
    while (r_beats <= int'(len) && cyc < TMO) begin
      bus.r_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      #1;
      if (bus.r_valid && r_lat < 0) r_lat = cyc;
      if (bus.r_valid && bus.r_ready) begin
        rd[r_beats] = bus.r_data;
        rr[r_beats] = bus.r_resp;
        rl[r_beats] = bus.r_last;
        r_id_got = bus.r_id;
        r_beats++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.r_ready = 1'b0;
    if (r_beats <= int'(len)) timeout("r");
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [1:0] r;
    r = 2'b00;
    bus_idle();
    model_clear();
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.aw_ready, bus.w_ready, bus.b_valid, bus.r_valid} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_hs got aw%b w%b b%b r%b want 0000", bus.aw_ready, bus.w_ready, bus.b_valid, bus.r_valid);
    end
    n_cmp++;
    if (regs_o !== '0) begin
      n_bad++;
      $display("FAIL reset_regs got %h want 0", regs_o);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    r = {bus.aw_ready, bus.ar_ready};
    n_cmp++;
    if (r !== 2'b11) begin
      n_bad++;
      $display("FAIL reset_release_ready got %b want 11", r);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [1:0] er;
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(3'd5, 32'h2200_0004, 8'd0, 3'd2, BURST_INCR);
    model_write(32'h2200_0004, 0, 3'd2, BURST_INCR, er);
    n_cmp++;
    if ({b_resp_got, b_id_got} !== {RESP_OKAY, 3'd5}) begin
      n_bad++;
      $display("FAIL single_b got resp %b id %0d want 00 id 5", b_resp_got, b_id_got);
    end
    n_cmp++;
    if (w_lat !== 0 || b_lat !== 0) begin
      n_bad++;
      $display("FAIL single_w_timing got wlat %0d blat %0d want 0 0", w_lat, b_lat);
    end
    n_cmp++;
    if (regs_o[63:32] !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL single_regs got %h want deadbeef", regs_o[63:32]);
    end
    do_read(3'd5, 32'h2200_0004, 8'd0, 3'd2, BURST_INCR, 1'b0);
    n_cmp++;
    if ({rd[0], rr[0], rl[0], r_id_got} !== {32'hDEADBEEF, RESP_OKAY, 1'b1, 3'd5}) begin
      n_bad++;
      $display("FAIL single_r got %h resp %b last %b id %0d want deadbeef 00 1 5", rd[0], rr[0], rl[0], r_id_got);
    end
    n_cmp++;
    if (r_lat !== 0) begin
      n_bad++;
      $display("FAIL single_r_timing got %0d want 0", r_lat);
    end
  endtask

  task automatic test_strobe();
    logic [1:0] er;
    wd[0] = 32'h11223344; ws[0] = 4'h5;
    do_write(3'd1, 32'h2200_0004, 8'd0, 3'd2, BURST_INCR);
    model_write(32'h2200_0004, 0, 3'd2, BURST_INCR, er);
    do_read(3'd1, 32'h2200_0004, 8'd0, 3'd2, BURST_INCR, 1'b0);
    n_cmp++;
    if (rd[0] !== 32'hDE22BE44) begin
      n_bad++;
      $display("FAIL strobe got %h want de22be44", rd[0]);
    end
  endtask

  task automatic test_incr_burst();
    logic [1:0] er;
    for (int k = 0; k < 4; k++) begin
      wd[k] = 32'(k + 1); ws[k] = 4'hF;
    end
    do_write(3'd2, 32'h2200_0000, 8'd3, 3'd2, BURST_INCR);
    model_write(32'h2200_0000, 3, 3'd2, BURST_INCR, er);
    n_cmp++;
    if (b_resp_got !== RESP_OKAY) begin
      n_bad++;
      $display("FAIL incr_bresp got %b want 00", b_resp_got);
    end
    do_read(3'd2, 32'h2200_0000, 8'd3, 3'd2, BURST_INCR, 1'b1);
    n_cmp++;
    if (r_beats !== 4) begin
      n_bad++;
      $display("FAIL incr_beats got %0d want 4", r_beats);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({rd[k], rl[k]} !== {32'(k + 1), k == 3}) begin
        n_bad++;
        $display("FAIL incr_beat%0d got %h last %b want %h last %b", k, rd[k], rl[k], k + 1, k == 3);
      end
    end
    #1;
    n_cmp++;
    if (bus.r_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL incr_extra_beat got rvalid %b want 0", bus.r_valid);
    end
  endtask

  task automatic test_fixed_errors();
    logic [1:0] er;
    wd[0] = 32'd7; wd[1] = 32'd8; wd[2] = 32'd9;
    ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
    do_write(3'd3, 32'h2200_0008, 8'd2, 3'd2, BURST_FIXED);
    model_write(32'h2200_0008, 2, 3'd2, BURST_FIXED, er);
    n_cmp++;
    if ({b_resp_got, regs_o[95:64]} !== {RESP_OKAY, 32'd9}) begin
      n_bad++;
      $display("FAIL fixed got resp %b reg2 %h want 00 9", b_resp_got, regs_o[95:64]);
    end
    wd[0] = 32'hAAAA0001; wd[1] = 32'hBBBB0002;
    do_write(3'd4, 32'h2200_001C, 8'd1, 3'd2, BURST_INCR);
    model_write(32'h2200_001C, 1, 3'd2, BURST_INCR, er);
    n_cmp++;
    if ({b_resp_got, regs_o[255:224]} !== {RESP_SLVERR, 32'hAAAA0001}) begin
      n_bad++;
      $display("FAIL oor_write got resp %b reg7 %h want 10 aaaa0001", b_resp_got, regs_o[255:224]);
    end
    do_read(3'd4, 32'h2200_0020, 8'd0, 3'd2, BURST_INCR, 1'b0);
    n_cmp++;
    if ({rd[0], rr[0]} !== {32'd0, RESP_SLVERR}) begin
      n_bad++;
      $display("FAIL oor_read got %h resp %b want 0 10", rd[0], rr[0]);
    end
    wd[0] = 32'h55555555;
    do_write(3'd0, 32'h2200_0000, 8'd0, 3'd1, BURST_INCR);
    model_write(32'h2200_0000, 0, 3'd1, BURST_INCR, er);
    n_cmp++;
    if ({b_resp_got, regs_o} !== {RESP_SLVERR, model_flat()}) begin
      n_bad++;
      $display("FAIL size1 got resp %b regs %h want 10 %h", b_resp_got, regs_o, model_flat());
    end
    wd[0] = 32'h0BAD0BAD; wd[1] = 32'h600D600D;
    do_write(3'd6, 32'h2200_0FFC, 8'd1, 3'd2, BURST_INCR);
    model_write(32'h2200_0FFC, 1, 3'd2, BURST_INCR, er);
    n_cmp++;
    if ({b_resp_got, regs_o[31:0]} !== {RESP_SLVERR, 32'h600D600D}) begin
      n_bad++;
      $display("FAIL idx_wrap got resp %b reg0 %h want 10 600d600d", b_resp_got, regs_o[31:0]);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] er;
    wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
    bus.ar_id = 3'd6; bus.ar_addr = 32'h2200_0010;
    bus.ar_len = 8'd0; bus.ar_size = 3'd2;
    bus.ar_burst = BURST_INCR; bus.ar_valid = 1'b1;
    bus.aw_addr = 32'h2200_0010; bus.aw_valid = 1'b1;
    #1;
    n_cmp++;
    if ({bus.aw_ready, bus.ar_ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL simul_ready got aw%b ar%b want aw1 ar0", bus.aw_ready, bus.ar_ready);
    end
    do_write(3'd3, 32'h2200_0010, 8'd0, 3'd2, BURST_INCR);
    model_write(32'h2200_0010, 0, 3'd2, BURST_INCR, er);
    n_cmp++;
    if ({b_resp_got, b_id_got} !== {RESP_OKAY, 3'd3}) begin
      n_bad++;
      $display("FAIL simul_b got resp %b id %0d want 00 3", b_resp_got, b_id_got);
    end
    do_read(3'd6, 32'h2200_0010, 8'd0, 3'd2, BURST_INCR, 1'b0);
    n_cmp++;
    if ({rd[0], r_id_got, r_beats} !== {32'hCAFEF00D, 3'd6, 32'd1}) begin
      n_bad++;
      $display("FAIL simul_r got %h id %0d beats %0d want cafef00d 6 1", rd[0], r_id_got, r_beats);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [1:0] er;
    int t;
    for (int k = 0; k < 4; k++) begin
      wd[k] = $urandom; ws[k] = 4'hF;
    end
    do_write(3'd1, 32'h2200_0000, 8'd3, 3'd2, BURST_INCR);
    model_write(32'h2200_0000, 3, 3'd2, BURST_INCR, er);
    bus.ar_id = 3'd1; bus.ar_addr = 32'h2200_0000;
    bus.ar_len = 8'd3; bus.ar_size = 3'd2;
    bus.ar_burst = BURST_INCR; bus.ar_valid = 1'b1;
    #1; t = 0;
    while (!bus.ar_ready && t < TMO) begin
      @(negedge clk); #1; t++;
    end
    if (t >= TMO) timeout("rst_ar");
    @(negedge clk);
    bus.ar_valid = 1'b0; bus.r_ready = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.r_valid, bus.r_data} !== {1'b1, model[1]}) begin
      n_bad++;
      $display("FAIL rst_beat2 got v%b %h want v1 %h", bus.r_valid, bus.r_data, model[1]);
    end
    rst = 1'b1;
    model_clear();
    #1;
    n_cmp++;
    if ({bus.r_valid, bus.aw_ready, regs_o} !== {2'b00, model_flat()}) begin
      n_bad++;
      $display("FAIL rst_async got rv%b aw%b regs %h want 0 0 0", bus.r_valid, bus.aw_ready, regs_o);
    end
    bus_idle();
    @(negedge clk);
    rst = 1'b0;
    do_read(3'd2, 32'h2200_0004, 8'd0, 3'd2, BURST_INCR, 1'b0);
    n_cmp++;
    if ({r_beats, rd[0], rr[0], r_id_got} !== {32'd1, 32'd0, RESP_OKAY, 3'd2}) begin
      n_bad++;
      $display("FAIL rst_new_ar got beats %0d %h resp %b id %0d want 1 0 00 2", r_beats, rd[0], rr[0], r_id_got);
    end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size, id;
    logic [1:0]  burst, er;
    int          pick, idx;
    logic [31:0] ed;
    logic [1:0]  eresp;
    for (int n = 0; n < 60; n++) begin
      pick = $urandom_range(0, 15);
      addr = 32'h2200_0000 + ((pick < 12) ? 32'(pick * 4)
                                          : 32'(32'hFF0 + (pick - 12) * 4));
      len = 8'($urandom_range(0, 5));
      size = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
      burst = ($urandom_range(0, 5) == 0) ? BURST_WRAP
                                          : 2'($urandom_range(0, 1));
      id = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        for (int k = 0; k <= int'(len); k++) begin
          wd[k] = $urandom; ws[k] = 4'($urandom_range(0, 15));
        end
        do_write(id, addr, len, size, burst);
        model_write(addr, int'(len), size, burst, er);
        n_cmp++;
        if ({b_resp_got, b_id_got, regs_o} !== {er, id, model_flat()}) begin
          n_bad++;
          $display("FAIL rnd_write%0d got resp %b id %0d regs %h want %b %0d %h", n, b_resp_got, b_id_got, regs_o, er, id, model_flat());
        end
      end else begin
        do_read(id, addr, len, size, burst, $urandom_range(0, 1) == 1);
        n_cmp++;
        if ({r_beats, r_id_got} !== {32'(len) + 32'd1, id}) begin
          n_bad++;
          $display("FAIL rnd_read%0d_beats got %0d id %0d want %0d id %0d", n, r_beats, r_id_got, len + 1, id);
        end
        for (int k = 0; k <= int'(len); k++) begin
          idx = m_idx(addr, burst, k);
          ed = m_ok(size, burst, idx) ? model[idx] : 32'd0;
          eresp = m_ok(size, burst, idx) ? RESP_OKAY : RESP_SLVERR;
          n_cmp++;
          if ({rd[k], rr[k], rl[k]} !== {ed, eresp, k == int'(len)}) begin
            n_bad++;
            $display("FAIL rnd_read%0d_beat%0d got %h %b %b want %h %b %b", n, k, rd[k], rr[k], rl[k], ed, eresp, k == int'(len));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_strobe();
    test_incr_burst();
    test_fixed_errors();
    test_simultaneous();
    test_random();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
